drift_tdc_bank: RTL



---
 rtl/tdc_pkg.sv | 16 +
 rtl/sync_edge.sv | 36 +++
 rtl/drift_tdc_bank.sv | 118 +++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the drift-tube TDC bank.
// Holds the event FSM states and the drop-counter width.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int N_CH_DEF   = 8;
  localparam int TW_DEF     = 8;
  localparam int WINDOW_DEF = 255;
  localparam int DROP_W     = 8;

endpackage

// File: rtl/sync_edge.sv
// Async-pin synchroniser plus registered rising-edge pulse; pin-to-pulse latency SYNC_STAGES+1 cycles.
// No flow control: one single-cycle pulse per synced 0->1 transition.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk100,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
    edge_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      edge_q <= edge_d;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/drift_tdc_bank.sv
// Per-layer drift TDC: trigger opens a WINDOW+1 cycle window, first tube edges are timestamped; evt_valid WINDOW+2 cycles after trigger edge.
// Snapshot is held until evt_valid & evt_ready; triggers arriving while busy are dropped and counted.
module drift_tdc_bank
  import tdc_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int TW          = TW_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk100,
  input  logic                 rst_n,
  input  logic                 scin_coin,
  input  logic [N_CH-1:0]      tube_in,
  output logic [N_CH*TW-1:0]   hit_time,
  output logic [N_CH-1:0]      hit_mask,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic                 busy,
  output logic [DROP_W-1:0]    drop_cnt
);

  localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW);

  logic            trig_edge;
  logic [N_CH-1:0] tube_edge;

  // Trigger and tubes use identical synchronisers so relative timing is preserved.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_trig (
    .clk100   (clk100),
    .rst_n    (rst_n),
    .async_in (scin_coin),
    .edge_o   (trig_edge)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_tube
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tube (
      .clk100   (clk100),
      .rst_n    (rst_n),
      .async_in (tube_in[g]),
      .edge_o   (tube_edge[g])
    );
  end

  state_e              state_q, state_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic [N_CH*TW-1:0]  time_q, time_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      time_q  <= '0;
      mask_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      mask_q  <= mask_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig_edge)          state_d = ARMED;
      ARMED:   if (cnt_q == WIN_LAST)  state_d = HOLD;
      HOLD:    if (evt_ready)          state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    time_d = time_q;
    mask_d = mask_q;
    drop_d = drop_q;
    case (state_q)
      IDLE: begin
        if (trig_edge) cnt_d = '0;
      end
      ARMED: begin
        cnt_d = cnt_q + TW'(1);
        for (int i = 0; i < N_CH; i++) begin
          if (tube_edge[i] && !mask_q[i]) begin
            time_d[i*TW +: TW] = cnt_q;
            mask_d[i]          = 1'b1;
          end
        end
      end
      HOLD: begin
        if (evt_ready) begin
          time_d = '0;
          mask_d = '0;
        end
      end
      default: ;
    endcase
    // Includes the handshake cycle, where the FSM is still HOLD.
    if (trig_edge && (state_q != IDLE) && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_comb begin
    evt_valid = (state_q == HOLD);
    busy      = (state_q != IDLE);
  end

  assign hit_time = time_q;
  assign hit_mask = mask_q;
  assign drop_cnt = drop_q;

endmodule
